// File: rtl/dma_if.sv
// Register-port and bus-master bundles for the dma block.
// dma_reg_if: CPU-side register window; dma_bus_if: memory-side word bus.

interface dma_reg_if;
   logic [31:0] address_in;
   logic        sel_in;
   logic        read_in;
   logic [3:0]  write_mask_in;
   logic [31:0] write_value_in;
   logic [31:0] read_value_out;
   logic        ready_out;

   modport master (
      output address_in, sel_in, read_in,
      output write_mask_in, write_value_in,
      input  read_value_out, ready_out
   );

   modport slave (
      input  address_in, sel_in, read_in,
      input  write_mask_in, write_value_in,
      output read_value_out, ready_out
   );
endinterface

interface dma_bus_if;
   logic [31:0] address_out;
   logic        read_out;
   logic        write_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        ready_in;
   logic        fault_in;

   modport master (
      output address_out, read_out, write_out,
      output write_mask_out, write_value_out,
      input  read_value_in, ready_in, fault_in
   );

   modport slave (
      input  address_out, read_out, write_out,
      input  write_mask_out, write_value_out,
      output read_value_in, ready_in, fault_in
   );
endinterface

// File: rtl/dma.sv
// Single-channel word DMA: copies LEN words from SRC to DST, one bus beat per state.
// Ports: clk, reset (async, active-low), cfg (dma_reg_if.slave register window:
//   0 SRC, 1 DST, 2 LEN, 3 CTRL), bus (dma_bus_if.master word bus).
// CTRL: bit0 START/BUSY, bit1 DONE (w1c), bit2 ERR (w1c), bit3 ABORT (wo).
// Optional DMA_IRQ_EN: adds irq_out and CTRL bit4 IRQEN.

module dma #(
   parameter int LEN_BITS = 16
) (
   input  logic      clk,
   input  logic      reset,
   dma_reg_if.slave  cfg,
   dma_bus_if.master bus
`ifdef DMA_IRQ_EN
   ,
   output logic      irq_out
`endif
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t              state_q, state_d;
   logic [31:0]         src_q, dst_q, buf_q;
   logic [LEN_BITS-1:0] len_q;
   logic                done_q, err_q, abort_q;
   logic                busy, wr_en, ctl_w, start;
   logic                clr_done, clr_err, abort_w, abort_now;
   logic                beat_rd, beat_wr, go, set_done, set_err;
   logic                irq_bit;
   logic [1:0]          ra;
   logic [31:0]         wd, len_ext, len_wr;
   logic                unused_bits;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  m
   );
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (m[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   assign busy      = (state_q != IDLE);
   assign ra        = cfg.address_in[3:2];
   assign wd        = cfg.write_value_in;
   assign wr_en     = cfg.sel_in & ~cfg.read_in & (|cfg.write_mask_in);
   assign ctl_w     = wr_en & (ra == 2'd3) & cfg.write_mask_in[0];
   assign start     = ctl_w & wd[0] & ~busy;
   assign clr_done  = ctl_w & wd[1];
   assign clr_err   = ctl_w & wd[2];
   assign abort_w   = ctl_w & wd[3] & busy;
   assign abort_now = abort_q | abort_w;
   assign len_ext   = 32'(len_q);
   assign len_wr    = lane_merge(len_ext, wd, cfg.write_mask_in);
   assign unused_bits = ^{cfg.address_in[31:4], cfg.address_in[1:0],
                          len_wr[31:LEN_BITS]};

   assign cfg.ready_out = cfg.sel_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d             = state_q;
      beat_rd             = 1'b0;
      beat_wr             = 1'b0;
      go                  = 1'b0;
      set_done            = 1'b0;
      set_err             = 1'b0;
      bus.address_out     = '0;
      bus.read_out        = 1'b0;
      bus.write_out       = 1'b0;
      bus.write_mask_out  = '0;
      bus.write_value_out = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len_q != '0) begin
                  go      = 1'b1;
                  state_d = RD;
               end else begin
                  set_done = 1'b1;
               end
            end
         end
         RD: begin
            bus.address_out = src_q;
            bus.read_out    = 1'b1;
            if (bus.ready_in) begin
               if (abort_now) begin
                  state_d = IDLE;
               end else if (bus.fault_in) begin
                  set_err = 1'b1;
                  state_d = IDLE;
               end else begin
                  beat_rd = 1'b1;
                  state_d = WR;
               end
            end
         end
         WR: begin
            bus.address_out     = dst_q;
            bus.write_out       = 1'b1;
            bus.write_mask_out  = 4'hF;
            bus.write_value_out = buf_q;
            if (bus.ready_in) begin
               // A completed write still advances the pointers, even when aborting.
               beat_wr = ~bus.fault_in;
               if (abort_now) begin
                  state_d = IDLE;
               end else if (bus.fault_in) begin
                  set_err = 1'b1;
                  state_d = IDLE;
               end else if (len_q == LEN_BITS'(1)) begin
                  set_done = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         buf_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         if (wr_en && ra == 2'd0 && !busy)
            src_q <= lane_merge(src_q, wd, cfg.write_mask_in) & ~32'h3;
         else if (beat_wr)
            src_q <= src_q + 32'd4;
         if (wr_en && ra == 2'd1 && !busy)
            dst_q <= lane_merge(dst_q, wd, cfg.write_mask_in) & ~32'h3;
         else if (beat_wr)
            dst_q <= dst_q + 32'd4;
         if (wr_en && ra == 2'd2 && !busy)
            len_q <= len_wr[LEN_BITS-1:0];
         else if (beat_wr)
            len_q <= len_q - LEN_BITS'(1);
         if (beat_rd)
            buf_q <= bus.read_value_in;
         // Clear beats set when both land in the same cycle.
         done_q  <= (done_q | set_done) & ~go & ~clr_done;
         err_q   <= (err_q | set_err) & ~go & ~clr_err;
         abort_q <= abort_now & (state_d != IDLE);
      end
   end

`ifdef DMA_IRQ_EN
   logic irqen_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irqen_q <= 1'b0;
         irq_out <= 1'b0;
      end else begin
         if (ctl_w) irqen_q <= wd[4];
         irq_out <= irqen_q & (done_q | err_q);
      end
   end

   assign irq_bit = irqen_q;
`else
   assign irq_bit = 1'b0;
`endif

   always_comb begin
      cfg.read_value_out = '0;
      if (cfg.sel_in) begin
         unique case (ra)
            2'd0:    cfg.read_value_out = src_q;
            2'd1:    cfg.read_value_out = dst_q;
            2'd2:    cfg.read_value_out = len_ext;
            default: cfg.read_value_out = {27'd0, irq_bit, 1'b0,
                                           err_q, done_q, busy};
         endcase
      end
   end

endmodule

// File: doc/dma.md
DMA -- requirements
Module: dma

Interface
REQ-001 SHALL have parameter: LEN_BITS, 16, width of the transfer-length counter in words (1..30).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have register-port inputs (responder side):
- address_in  in  32  byte address
- sel_in  in  1  register window selected
- read_in  in  1  read strobe
- write_mask_in  in  4  byte-lane write enables
- write_value_in  in  32  write data
REQ-005 SHALL have register-port outputs: read_value_out  out  32  register data; ready_out  out  1  access complete.
REQ-006 SHALL have bus-master outputs (initiator side):
- address_out  out  32  word address
- read_out  out  1  read request
- write_out  out  1  write request
- write_mask_out  out  4  byte enables
- write_value_out  out  32  write data
REQ-007 SHALL have bus-master inputs: read_value_in  in  32  read data; ready_in  in  1  beat complete; fault_in  in  1  bus fault.

Function
REQ-008 SHALL decode registers on address_in[3:2]: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
REQ-009 SHALL define CTRL as follows:
- bit0: START on write / BUSY on read
- bit1: DONE, sticky, write-1-clear
- bit2: ERR, sticky, write-1-clear
- bit3: ABORT, write-only, reads 0
REQ-010 SHALL assert ready_out combinationally whenever sel_in is high, with zero wait states.
REQ-011 SHALL drive read_value_out to 0 whenever sel_in is low, so the output can be OR-muxed.
REQ-012 SHALL apply register writes per byte lane from write_mask_in on the clk edge where sel_in is high.
REQ-013 SHALL hold SRC/DST bits [1:0] at 0; they read back as 0.
REQ-014 SHALL ignore writes to SRC, DST, LEN and START while BUSY.
REQ-015 SHALL implement FSM states IDLE, RD, WR.
REQ-016 SHALL handle START=1 written in IDLE as follows:
- LEN!=0: latch the working copies of SRC/DST/LEN, clear DONE/ERR, enter RD next cycle.
- LEN=0: set DONE next cycle with no bus beats.
REQ-017 SHALL, in RD, drive address_out=src with read_out=1, write_out=0 and write_mask_out=0, held stable until ready_in.
REQ-018 SHALL, on RD with ready_in and !fault_in, capture read_value_in into a 32-bit buffer and enter WR.
REQ-019 SHALL, in WR, drive address_out=dst with write_out=1, write_mask_out=4'hF and write_value_out=buffer, held until ready_in.
REQ-020 SHALL, on WR with ready_in and !fault_in, increment src and dst by 4 modulo 2^32 and decrement len; when len reaches 0, go IDLE and set DONE, otherwise go RD.
REQ-021 SHALL, on ready_in with fault_in in RD or WR, go IDLE, set ERR and not set DONE; the faulting address stays readable in the working SRC (RD) or DST (WR).
REQ-022 SHALL, on ABORT written while BUSY, finish the outstanding beat (wait for ready_in), then go IDLE with neither DONE nor ERR set.
REQ-023 SHALL treat ABORT written in IDLE as a no-op.
REQ-024 SHALL expose the working copies on SRC/DST/LEN reads while BUSY, and the final values after completion.
REQ-025 SHALL drive all master outputs to 0 in IDLE.
REQ-026 SHALL read BUSY as 1 exactly in RD or WR.
REQ-027 SHALL give priority to a clear of DONE/ERR over a set in the same cycle.
REQ-028 SHALL perform one beat per state; minimum throughput is 2 cycles per word when ready_in is high on every cycle.

Reset
REQ-029 SHALL, when reset is low (asynchronous), force the FSM to IDLE and clear SRC, DST, LEN, DONE, ERR, the buffer and all master outputs to 0.
REQ-030 SHALL abandon any in-flight beat on reset asserted mid-transfer, with no further bus requests until a new START.

Configuration
REQ-031 SHALL, with macro DMA_IRQ_EN defined, add port irq_out  out  1  and CTRL bit4 IRQEN (R/W, reset 0); irq_out=IRQEN & (DONE | ERR), registered, 0 on reset.
REQ-032 SHALL, with DMA_IRQ_EN undefined, omit irq_out, make bit4 read 0 and ignore writes to it.

Verification
REQ-033 SHALL cover: SRC=0x100, DST=0x200, LEN=3, START, ready_in always high -> 3 reads of 0x100/0x104/0x108, 3 writes of 0x200/0x204/0x208 with mask F, DONE after 6 beats, LEN reads 0.
REQ-034 SHALL cover: LEN=0 with START -> DONE=1 next cycle, read_out/write_out never asserted.
REQ-035 SHALL cover: LEN=2 with fault_in on the second read -> ERR=1, DONE=0, SRC reads 0x104, one write performed.
REQ-036 SHALL cover: SRC=0xFFFFFFFC, LEN=2 -> second read at 0x00000000 (wrap).
REQ-037 SHALL cover: ready_in held low 5 cycles in WR, then ABORT -> address/data stable throughout, IDLE after ready_in, DONE=ERR=0.
REQ-038 SHALL cover: reset pulled low mid-RD -> all outputs 0 immediately; with DMA_IRQ_EN and IRQEN=1, irq_out=1 after completion and drops after a write-1-clear of DONE.
